// File: rtl/score_display.sv
// Score readout: binary score -> 5-digit BCD (sequential double-dabble), then
// time-multiplexed onto a 5-digit seven-segment display with leading-zero blanking.
module score_display #(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score,
    input  logic [1:0]  current_state,
    output logic [19:0] bcd,
    output logic        bcd_valid,
    output logic [4:0]  an,
    output logic [6:0]  seg
);

    localparam logic [4:0] AN_OFF  = SEG_ACTIVE_LOW ? 5'h1f : 5'h00;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
    localparam logic [1:0] ST_IDLE = 2'd0;

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_SHIFT,
        CV_COMMIT
    } cv_state_t;

    cv_state_t   cv_state_reg;
    logic [15:0] snap_reg;
    logic [15:0] shreg_reg;
    logic [19:0] work_reg;
    logic [19:0] work_adj;
    logic [4:0]  count_reg;
    logic        force_conv_reg;
    logic [19:0] bcd_reg;
    logic        bcd_valid_reg;

    logic [15:0] scan_cnt_reg;
    logic [2:0]  digit_idx_reg;
    logic [4:0]  an_reg;
    logic [6:0]  seg_reg;

    logic [2:0]  msd;
    logic [3:0]  cur_nib;
    logic        show;
    logic [4:0]  an_next;
    logic [6:0]  seg_next;

    // Add-3 correction of every BCD nibble before each shift.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_adj
            assign work_adj[gi*4 +: 4] = (work_reg[gi*4 +: 4] >= 4'd5)
                                       ? work_reg[gi*4 +: 4] + 4'd3
                                       : work_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cv_state_reg   <= CV_IDLE;
            snap_reg       <= 16'd0;
            shreg_reg      <= 16'd0;
            work_reg       <= 20'd0;
            count_reg      <= 5'd0;
            force_conv_reg <= 1'b1;
            bcd_reg        <= 20'd0;
            bcd_valid_reg  <= 1'b0;
        end else begin
            case (cv_state_reg)
                CV_IDLE: begin
                    if (force_conv_reg || (score != snap_reg)) begin
                        snap_reg       <= score;
                        shreg_reg      <= score;
                        work_reg       <= 20'd0;
                        count_reg      <= 5'd16;
                        force_conv_reg <= 1'b0;
                        cv_state_reg   <= CV_SHIFT;
                    end
                end
                CV_SHIFT: begin
                    work_reg  <= {work_adj[18:0], shreg_reg[15]};
                    shreg_reg <= {shreg_reg[14:0], 1'b0};
                    count_reg <= count_reg - 5'd1;
                    if (count_reg == 5'd1) begin
                        cv_state_reg <= CV_COMMIT;
                    end
                end
                CV_COMMIT: begin
                    bcd_reg       <= work_reg;
                    bcd_valid_reg <= 1'b1;
                    cv_state_reg  <= CV_IDLE;
                end
                default: cv_state_reg <= CV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_reg  <= 16'd0;
            digit_idx_reg <= 3'd0;
        end else if (scan_cnt_reg == SCAN_DIV - 16'd1) begin
            scan_cnt_reg  <= 16'd0;
            digit_idx_reg <= (digit_idx_reg == 3'd4) ? 3'd0 : digit_idx_reg + 3'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 16'd1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3f;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5b;
            4'd3:    seg7 = 7'h4f;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6d;
            4'd6:    seg7 = 7'h7d;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7f;
            4'd9:    seg7 = 7'h6f;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Highest nonzero digit; digit 0 is always lit so a zero score reads "0".
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 5; i++) begin
            if (bcd_reg[i*4 +: 4] != 4'd0) begin
                msd = 3'(i);
            end
        end
    end

    always_comb begin
        case (digit_idx_reg)
            3'd0:    cur_nib = bcd_reg[3:0];
            3'd1:    cur_nib = bcd_reg[7:4];
            3'd2:    cur_nib = bcd_reg[11:8];
            3'd3:    cur_nib = bcd_reg[15:12];
            3'd4:    cur_nib = bcd_reg[19:16];
            default: cur_nib = 4'hf;
        endcase
    end

    always_comb begin
        show     = bcd_valid_reg && (current_state != ST_IDLE) && (digit_idx_reg <= msd);
        an_next  = 5'd0;
        seg_next = 7'd0;
        if (show) begin
            an_next  = 5'b00001 << digit_idx_reg;
            seg_next = seg7(cur_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_reg  <= AN_OFF;
            seg_reg <= SEG_OFF;
        end else begin
            an_reg  <= an_next ^ AN_OFF;
            seg_reg <= seg_next ^ SEG_OFF;
        end
    end

    assign bcd       = bcd_reg;
    assign bcd_valid = bcd_valid_reg;
    assign an        = an_reg;
    assign seg       = seg_reg;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: commits are checked by a scoreboard monitor (value and
// exact cycle); scan/blanking is checked on an active-high and an active-low instance.
module tb_score_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] score;
    logic [1:0]  current_state;
    logic [19:0] bcd_h, bcd_l;
    logic        valid_h, valid_l;
    logic [4:0]  an_h, an_l;
    logic [6:0]  seg_h, seg_l;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [19:0] val;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    score_display #(.SCAN_DIV(16'd4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .score(score), .current_state(current_state),
        .bcd(bcd_h), .bcd_valid(valid_h), .an(an_h), .seg(seg_h)
    );

    score_display #(.SCAN_DIV(16'd4), .SEG_ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .score(score), .current_state(current_state),
        .bcd(bcd_l), .bcd_valid(valid_l), .an(an_l), .seg(seg_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 7'h3f;  4'd1: enc = 7'h06;  4'd2: enc = 7'h5b;
            4'd3: enc = 7'h4f;  4'd4: enc = 7'h66;  4'd5: enc = 7'h6d;
            4'd6: enc = 7'h7d;  4'd7: enc = 7'h07;  4'd8: enc = 7'h7f;
            4'd9: enc = 7'h6f;  default: enc = 7'h00;
        endcase
    endfunction

    // Monitor: a commit is visible as bcd_valid rising or bcd changing value.
    initial begin
        logic        prev_valid;
        logic [19:0] prev_bcd;
        exp_t        e;
        prev_valid = 1'b0;
        prev_bcd   = 20'd0;
        forever begin
            @(negedge clk);
            if (valid_h && (!prev_valid || bcd_h != prev_bcd)) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_commit: got %05h, expected none (cycle %0d)", bcd_h, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("commit_value", 32'(bcd_h), 32'(e.val));
                    chk("commit_cycle", 32'(cyc), 32'(e.due));
                    chk("commit_value_lowact", 32'(bcd_l), 32'(e.val));
                end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
                e = sb_q.pop_front();
                total++; bad++;
                $display("FAIL late_commit: got no commit of %05h, expected by cycle %0d", e.val, e.due);
            end
            prev_valid = valid_h;
            prev_bcd   = bcd_h;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_conv(logic [19:0] v, int d);
        sb_q.push_back('{val: v, due: cyc + d});
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
            sb_q.delete();
        end
        tick(2);
    endtask

    // One full scan round (5 digits x 4 cycles): each lit digit must be on for
    // exactly 4 cycles with the right pattern, blanked digits never.
    task automatic disp_check(string name, logic [4:0] lit_mask, logic [19:0] digits);
        int cnt_h[5];
        int cnt_l[5];
        int err_h = 0;
        int err_l = 0;
        logic [4:0] an_n;
        logic [6:0] seg_n;
        for (int i = 0; i < 5; i++) begin
            cnt_h[i] = 0;
            cnt_l[i] = 0;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            an_n  = ~an_l;
            seg_n = ~seg_l;
            if ($countones(an_h) > 1) err_h++;
            if ($countones(an_n) > 1) err_l++;
            if (an_h == 5'd0 && seg_h != 7'd0) err_h++;
            if (an_n == 5'd0 && seg_n != 7'd0) err_l++;
            for (int i = 0; i < 5; i++) begin
                if (an_h[i]) begin
                    cnt_h[i]++;
                    if (seg_h !== enc(digits[i*4 +: 4])) err_h++;
                end
                if (an_n[i]) begin
                    cnt_l[i]++;
                    if (seg_n !== enc(digits[i*4 +: 4])) err_l++;
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_an%0d_cycles", name, i), 32'(cnt_h[i]), lit_mask[i] ? 32'd4 : 32'd0);
            chk($sformatf("%s_an%0d_cycles_lowact", name, i), 32'(cnt_l[i]), lit_mask[i] ? 32'd4 : 32'd0);
        end
        chk({name, "_seg_errors"}, 32'(err_h), 32'd0);
        chk({name, "_seg_errors_lowact"}, 32'(err_l), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        score = 16'd0;
        current_state = 2'd2;
        tick(3);
        chk("reset_bcd", 32'(bcd_h), 32'd0);
        chk("reset_valid", 32'(valid_h), 32'd0);
        chk("reset_an", 32'(an_h), 32'h00);
        chk("reset_seg", 32'(seg_h), 32'h00);
        chk("reset_an_lowact", 32'(an_l), 32'h1f);
        chk("reset_seg_lowact", 32'(seg_l), 32'h7f);

        rst = 1'b0;
        expect_conv(20'h00000, 18);
        drain();
        chk("zero_an_lowact", 32'(an_l | 5'b00001), 32'h1f);
        disp_check("zero", 5'b00001, 20'h00000);

        score = 16'd12345;
        expect_conv(20'h12345, 18);
        drain();
        disp_check("d12345", 5'b11111, 20'h12345);

        score = 16'd65535;
        expect_conv(20'h65535, 18);
        drain();
        disp_check("d65535", 5'b11111, 20'h65535);

        score = 16'd42;
        expect_conv(20'h00042, 18);
        drain();
        disp_check("d42", 5'b00011, 20'h00042);

        // Change arrives mid-conversion: old value commits, new one follows.
        score = 16'd100;
        expect_conv(20'h00100, 18);
        expect_conv(20'h00200, 36);
        tick(5);
        score = 16'd200;
        drain();
        disp_check("d200", 5'b00111, 20'h00200);

        current_state = 2'd0;
        score = 16'd999;
        expect_conv(20'h00999, 18);
        drain();
        disp_check("idle", 5'b00000, 20'h00999);
        current_state = 2'd2;
        chk("idle_bcd_ready", 32'(bcd_h), 32'h00999);
        tick(2);
        disp_check("d999", 5'b00111, 20'h00999);

        // Reset during the shift phase of 5000.
        score = 16'd5000;
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("midrst_bcd", 32'(bcd_h), 32'd0);
        chk("midrst_valid", 32'(valid_h), 32'd0);
        chk("midrst_an_lowact", 32'(an_l), 32'h1f);
        chk("midrst_seg_lowact", 32'(seg_l), 32'h7f);
        rst = 1'b0;
        expect_conv(20'h05000, 18);
        drain();
        disp_check("d5000", 5'b01111, 20'h05000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
